// File: rtl/next_pc_ctrl.sv
// Program counter owner for the pipelined CPU: picks sequential, branch or jump next-PC,
// freezes on hazard stalls, defers redirects seen during a stall, and counts applied redirects.
module next_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             branch_i,
  input  logic [31:0]      branch_target_i,
  input  logic             jump_i,
  input  logic [25:0]      jump_addr_i,
  input  logic [31:0]      id_pc_i,
  output logic [31:0]      pc_o,
  output logic             pc_valid_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  typedef struct packed {
    logic        vld;
    logic [31:0] tgt;
  } redir_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q;
  logic             apply;
  logic [31:0]      id_pc4;
  redir_t           redir;

  // Jump region comes from the PC of the delay-slot successor, not the jump itself.
  always_comb begin
    id_pc4    = id_pc_i + 32'd4;
    redir.vld = branch_i | jump_i;
    redir.tgt = branch_i ? branch_target_i : {id_pc4[31:28], jump_addr_i, 2'b00};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= 32'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      if (apply && (cnt_q != '1)) cnt_q <= cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (redir.vld && stall_i) state_d = HOLD;
      HOLD:    if (!stall_i) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Datapath select; a same-cycle redirect out of HOLD beats the deferred one.
  always_comb begin
    apply  = 1'b0;
    pc_d   = pc_q;
    pend_d = pend_q;
    case (state_q)
      RUN: begin
        if (stall_i) begin
          if (redir.vld) pend_d = redir.tgt;
        end else if (redir.vld) begin
          pc_d  = redir.tgt;
          apply = 1'b1;
        end else begin
          pc_d = pc_q + 32'd4;
        end
      end
      HOLD: begin
        if (stall_i) begin
          if (redir.vld) pend_d = redir.tgt;
        end else begin
          pc_d  = redir.vld ? redir.tgt : pend_q;
          apply = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign pc_o           = pc_q;
  assign pc_valid_o     = (state_q != IDLE) && !rst_i;
  assign flush_o        = apply && !rst_i;
  assign redirect_cnt_o = cnt_q;

endmodule

// File: tb/tb_next_pc_ctrl.sv
// Directed bench for next_pc_ctrl: per-cycle expectations queued at drive time, checked after the edge.
module tb_next_pc_ctrl;

  localparam logic [31:0] RPC = 32'h0000_0100;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [1:0]  cnt;
    logic        vld;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_i, start_i, stall_i, branch_i, jump_i;
  logic [31:0] branch_target_i, id_pc_i;
  logic [25:0] jump_addr_i;
  logic [31:0] pc_o;
  logic        pc_valid_o, flush_o;
  logic [1:0]  redirect_cnt_o;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  next_pc_ctrl #(.RESET_PC(RPC), .CNT_W(2)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .branch_i(branch_i), .branch_target_i(branch_target_i),
    .jump_i(jump_i), .jump_addr_i(jump_addr_i), .id_pc_i(id_pc_i),
    .pc_o(pc_o), .pc_valid_o(pc_valid_o), .flush_o(flush_o),
    .redirect_cnt_o(redirect_cnt_o)
  );

  always #5 clk = ~clk;

  // Drive one cycle, check flush before the edge, queue post-edge expectation, then check it.
  task automatic step(input string tag, input logic rst, input logic strt, input logic st,
                      input logic br, input logic [31:0] bt, input logic jp,
                      input logic [25:0] ja, input logic [31:0] idpc,
                      input logic e_flush, input logic [31:0] e_pc,
                      input logic [1:0] e_cnt, input logic e_vld);
    exp_t e, g;
    @(negedge clk);
    rst_i = rst; start_i = strt; stall_i = st; branch_i = br; branch_target_i = bt;
    jump_i = jp; jump_addr_i = ja; id_pc_i = idpc;
    #1;
    total++;
    assert (flush_o === e_flush) else begin
      bad++; $error("FAIL %s flush got=%0b exp=%0b", tag, flush_o, e_flush);
    end
    e.tag = tag; e.pc = e_pc; e.cnt = e_cnt; e.vld = e_vld;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    total++;
    assert (pc_o === g.pc) else begin
      bad++; $error("FAIL %s pc got=%08h exp=%08h", g.tag, pc_o, g.pc);
    end
    total++;
    assert (redirect_cnt_o === g.cnt) else begin
      bad++; $error("FAIL %s cnt got=%0d exp=%0d", g.tag, redirect_cnt_o, g.cnt);
    end
    total++;
    assert (pc_valid_o === g.vld) else begin
      bad++; $error("FAIL %s valid got=%0b exp=%0b", g.tag, pc_valid_o, g.vld);
    end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0; branch_i = 1'b0; jump_i = 1'b0;
    branch_target_i = '0; jump_addr_i = '0; id_pc_i = '0;
    //   tag        rst  strt st  br  bt            jp  ja          idpc          fl  pc            cnt vld
    step("rst0",    1,   0,   0,  1,  32'h0000_0700, 0, 26'h0,      32'h0,        0,  RPC,          0,  0);
    step("rst1",    1,   1,   0,  0,  32'h0,        0, 26'h0,      32'h0,        0,  RPC,          0,  0);
    step("idle_br", 0,   0,   1,  1,  32'h0000_0700, 1, 26'h0,      32'h0,        0,  RPC,          0,  0);
    step("start",   0,   1,   0,  0,  32'h0,        0, 26'h0,      32'h0,        0,  RPC,          0,  1);
    step("seq1",    0,   0,   0,  0,  32'h0,        0, 26'h0,      32'h0,        0,  32'h104,      0,  1);
    step("seq2",    0,   1,   0,  0,  32'h0,        0, 26'h0,      32'h0,        0,  32'h108,      0,  1);
    step("jump",    0,   0,   0,  0,  32'h0,        1, 26'h000010, 32'h1000_0040, 1, 32'h1000_0040, 1, 1);
    step("seq3",    0,   0,   0,  0,  32'h0,        0, 26'h0,      32'h0,        0,  32'h1000_0044, 1, 1);
    step("br_jp",   0,   0,   0,  1,  32'h0000_0200, 1, 26'h000010, 32'h1000_0040, 1, 32'h200,     2,  1);
    step("hold_in", 0,   0,   1,  1,  32'h0000_0300, 0, 26'h0,      32'h0,        0,  32'h200,      2,  1);
    step("hold_a",  0,   0,   1,  0,  32'h0,        0, 26'h0,      32'h0,        0,  32'h200,      2,  1);
    step("hold_b",  0,   0,   1,  0,  32'h0,        0, 26'h0,      32'h0,        0,  32'h200,      2,  1);
    step("release", 0,   0,   0,  0,  32'h0,        0, 26'h0,      32'h0,        1,  32'h300,      3,  1);
    step("seq4",    0,   0,   0,  0,  32'h0,        0, 26'h0,      32'h0,        0,  32'h304,      3,  1);
    step("ovw_in",  0,   0,   1,  1,  32'h0000_0500, 0, 26'h0,      32'h0,        0,  32'h304,      3,  1);
    step("ovw_jp",  0,   0,   1,  0,  32'h0,        1, 26'h000200, 32'h0,        0,  32'h304,      3,  1);
    step("ovw_rel", 0,   0,   0,  0,  32'h0,        0, 26'h0,      32'h0,        1,  32'h800,      3,  1);
    step("win_in",  0,   0,   1,  1,  32'h0000_0A00, 0, 26'h0,      32'h0,        0,  32'h800,      3,  1);
    step("win_rel", 0,   0,   0,  1,  32'h0000_0900, 0, 26'h0,      32'h0,        1,  32'h900,      3,  1);
    step("run_stl", 0,   0,   1,  0,  32'h0,        0, 26'h0,      32'h0,        0,  32'h900,      3,  1);
    step("seq5",    0,   0,   0,  0,  32'h0,        0, 26'h0,      32'h0,        0,  32'h904,      3,  1);
    step("to_top",  0,   0,   0,  1,  32'hFFFF_FFFC, 0, 26'h0,      32'h0,        1,  32'hFFFF_FFFC, 3, 1);
    step("wrap",    0,   0,   0,  0,  32'h0,        0, 26'h0,      32'h0,        0,  32'h0,        3,  1);
    step("h6_in",   0,   0,   1,  1,  32'h0000_0400, 0, 26'h0,      32'h0,        0,  32'h0,        3,  1);
    step("h6_rst",  1,   0,   0,  0,  32'h0,        0, 26'h0,      32'h0,        0,  RPC,          0,  0);
    step("h6_idle", 0,   0,   0,  0,  32'h0,        0, 26'h0,      32'h0,        0,  RPC,          0,  0);
    step("h6_strt", 0,   1,   0,  0,  32'h0,        0, 26'h0,      32'h0,        0,  RPC,          0,  1);
    step("h6_seq",  0,   0,   0,  0,  32'h0,        0, 26'h0,      32'h0,        0,  32'h104,      0,  1);
    total++;
    assert (exp_q.size() == 0) else begin
      bad++; $error("FAIL scoreboard leftover got=%0d exp=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
